// File: rtl/input_debouncer.sv
// input_debouncer: 2-flop synchroniser plus 4-state Moore debounce FSM for one raw input
// Ports:
//   clk        - single clock, all logic on posedge
//   reset      - synchronous active-high reset
//   raw_in     - raw asynchronous switch/button input
//   data_out   - debounced level (S_HIGH/S_FALL)
//   rise_pulse - registered 1-cycle pulse on data_out 0->1
//   fall_pulse - registered 1-cycle pulse on data_out 1->0
//   settling   - high while a candidate level change is being qualified
module input_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    output logic data_out,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic settling
);
    typedef enum logic [1:0] {S_LOW = 2'd0, S_RISE = 2'd1, S_HIGH = 2'd2, S_FALL = 2'd3} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    state_t state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic sync1, sync_in, rise_nxt, fall_nxt;
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1      <= 1'b0;
            sync_in    <= 1'b0;
            state      <= S_LOW;
            cnt        <= '0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            sync1      <= raw_in;
            sync_in    <= sync1;
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            rise_pulse <= rise_nxt;
            fall_pulse <= fall_nxt;
        end
    end
    // cnt holds the length of the current candidate run; it restarts on every glitch
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        case (state)
            S_LOW: if (sync_in) begin
                state_nxt = S_RISE;
                cnt_nxt   = CNT_W'(1);
            end
            S_RISE: if (!sync_in) state_nxt = S_LOW;
                else if (cnt == LAST) begin
                    state_nxt = S_HIGH;
                    rise_nxt  = 1'b1;
                end else cnt_nxt = cnt + 1'b1;
            S_HIGH: if (!sync_in) begin
                state_nxt = S_FALL;
                cnt_nxt   = CNT_W'(1);
            end
            S_FALL: if (sync_in) state_nxt = S_HIGH;
                else if (cnt == LAST) begin
                    state_nxt = S_LOW;
                    fall_nxt  = 1'b1;
                end else cnt_nxt = cnt + 1'b1;
        endcase
    end
    // encoding chosen so bit1 is the accepted level and bit0 marks qualification
    assign data_out = state[1];
    assign settling = state[0];
endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: table vectors, corner sequences and random stimulus against a run-length model
module tb_input_debouncer;
    localparam int N = 4;
    logic clk = 1'b0, reset = 1'b1, raw_in = 1'b1;
    logic data_out, rise_pulse, fall_pulse, settling;
    int vectors = 0, miscompares = 0;

    input_debouncer #(.DEBOUNCE_CYCLES(N), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .raw_in(raw_in), .data_out(data_out),
        .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .settling(settling)
    );

    always #5 clk = ~clk;

    // Model: the FSM sees raw_in delayed by two edges; a new level is accepted once
    // N consecutive delayed samples differ from the current level.
    bit m_pipe[$];
    bit m_level, m_rise, m_fall;
    int m_run;

    function automatic void model_step(input bit rst, input bit raw);
        bit s;
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (rst) begin
            m_pipe = '{1'b0, 1'b0};
            m_level = 1'b0;
            m_run = 0;
        end else begin
            s = m_pipe.pop_front();
            m_pipe.push_back(raw);
            if (s != m_level) begin
                m_run++;
                if (m_run == N) begin
                    m_level = s;
                    m_rise = s;
                    m_fall = !s;
                    m_run = 0;
                end
            end else m_run = 0;
        end
    endfunction

    task automatic apply(input bit rst, input bit raw);
        reset = rst;
        raw_in = raw;
        @(posedge clk);
        #1;
        model_step(rst, raw);
    endtask

    task automatic check(input string name, input logic [3:0] exp);
        logic [3:0] act;
        act = {data_out, rise_pulse, fall_pulse, settling};
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got data/rise/fall/settling=%b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string name);
        check(name, {m_level, m_rise, m_fall, m_run > 0});
    endtask

    task automatic check_excl(input string name);
        vectors++;
        if (rise_pulse && fall_pulse) begin
            miscompares++;
            $display("FAIL %s: rise_pulse=%b fall_pulse=%b expected not both 1", name, rise_pulse, fall_pulse);
        end
    endtask

    typedef struct {
        bit rst;
        bit raw;
        logic [3:0] exp;
    } vec_t;
    vec_t tbl[43];

    initial begin
        int len;
        bit raw;
        bit rst;
        m_pipe = '{1'b0, 1'b0};
        // {rst, raw, {data_out, rise, fall, settling}} - outputs after the edge
        tbl = '{
            '{1, 1, 4'b0000}, '{1, 1, 4'b0000},
            '{0, 1, 4'b0000}, '{0, 1, 4'b0000}, '{0, 1, 4'b0001}, '{0, 1, 4'b0001},
            '{0, 1, 4'b0001}, '{0, 1, 4'b1100}, '{0, 1, 4'b1000},
            '{0, 0, 4'b1000}, '{0, 1, 4'b1000}, '{0, 1, 4'b1001}, '{0, 1, 4'b1000},
            '{0, 0, 4'b1000}, '{0, 0, 4'b1000}, '{0, 0, 4'b1001}, '{0, 0, 4'b1001},
            '{0, 0, 4'b1001}, '{0, 0, 4'b0010}, '{0, 0, 4'b0000},
            '{0, 1, 4'b0000}, '{0, 1, 4'b0000}, '{0, 1, 4'b0001}, '{0, 0, 4'b0001},
            '{0, 0, 4'b0001}, '{0, 0, 4'b0000}, '{0, 0, 4'b0000},
            '{0, 1, 4'b0000}, '{0, 1, 4'b0000}, '{0, 1, 4'b0001}, '{1, 1, 4'b0000},
            '{0, 1, 4'b0000}, '{0, 1, 4'b0000}, '{0, 1, 4'b0001}, '{0, 1, 4'b0001},
            '{0, 1, 4'b0001}, '{0, 1, 4'b1100},
            '{0, 0, 4'b1000}, '{0, 0, 4'b1000}, '{0, 0, 4'b1001}, '{1, 0, 4'b0000},
            '{0, 0, 4'b0000}, '{0, 0, 4'b0000}
        };
        foreach (tbl[i]) begin
            apply(tbl[i].rst, tbl[i].raw);
            check($sformatf("table%0d", i), tbl[i].exp);
            check_model($sformatf("table_model%0d", i));
        end
        // raw toggling every cycle: level holds, no pulses ever
        for (int i = 0; i < 50; i++) begin
            apply(1'b0, i[0]);
            check_model($sformatf("toggle%0d", i));
            vectors++;
            if (rise_pulse || fall_pulse || data_out) begin
                miscompares++;
                $display("FAIL toggle_quiet%0d: rise=%b fall=%b data=%b expected 0 0 0", i, rise_pulse, fall_pulse, data_out);
            end
        end
        // random runs of 1..8 cycles with occasional reset
        for (int k = 0; k < 600; k++) begin
            len = $urandom_range(1, 8);
            raw = 1'($urandom_range(0, 1));
            for (int j = 0; j < len; j++) begin
                rst = ($urandom_range(0, 99) == 0);
                apply(rst, raw);
                check_model($sformatf("rand%0d_%0d", k, j));
                check_excl($sformatf("rand_excl%0d_%0d", k, j));
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
